// File: rtl/axi_reg_arbiter.sv
// Round-robin two-client front end for the AXI-lite-style register slave.
// Serialises one full read or write at a time and times out missing responses.
module axi_reg_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  grant,
   output logic                  awvalid,
   output logic [ADDR_WIDTH-1:0] awaddr,
   input  logic                  awready,
   output logic                  wvalid,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic                  wready,
   input  logic                  wresp,
   output logic                  arvalid,
   output logic [ADDR_WIDTH-1:0] araddr,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rData,
   input  logic                  rvalid
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StWrite, StWresp, StRead, StRdata, StDone} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic                  ack0_d, ack1_d, err_d, busy_d, grant_d;
   logic                  awvalid_d, wvalid_d, arvalid_d;
   logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d, sel_addr;
   logic [DATA_WIDTH-1:0] wdata_d, rdata_d;
   logic                  sel, sel_we;
   logic                  timed_out;

   assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata;
      grant_d   = grant;
      awvalid_d = awvalid;
      awaddr_d  = awaddr;
      wvalid_d  = wvalid;
      wdata_d   = wdata;
      arvalid_d = arvalid;
      araddr_d  = araddr;
      // With both requesting, serve whichever was not served last.
      sel       = (req0 && req1) ? ~last_q : req1;
      sel_we    = sel ? we1 : we0;
      sel_addr  = sel ? addr1 : addr0;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               grant_d = sel;
               if (sel_we) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = sel_addr;
                  wdata_d   = sel ? wdata1 : wdata0;
                  state_d   = StWrite;
               end else begin
                  arvalid_d = 1'b1;
                  araddr_d  = sel_addr;
                  state_d   = StRead;
               end
            end
         end
         StWrite: begin
            awvalid_d = awvalid & ~awready;
            wvalid_d  = wvalid & ~wready;
            if (!awvalid_d && !wvalid_d) begin
               cnt_d   = '0;
               state_d = StWresp;
            end
         end
         StWresp: begin
            cnt_d = cnt_q + 1'b1;
            if (wresp || timed_out) begin
               err_d   = ~wresp;
               ack0_d  = ~grant;
               ack1_d  = grant;
               state_d = StDone;
            end
         end
         StRead: begin
            arvalid_d = ~arready;
            if (arready) begin
               cnt_d   = '0;
               state_d = StRdata;
            end
         end
         StRdata: begin
            cnt_d = cnt_q + 1'b1;
            if (rvalid || timed_out) begin
               rdata_d = rvalid ? rData : '0;
               err_d   = ~rvalid;
               ack0_d  = ~grant;
               ack1_d  = grant;
               state_d = StDone;
            end
         end
         StDone: begin
            last_d  = grant;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         busy    <= 1'b0;
         grant   <= 1'b0;
         awvalid <= 1'b0;
         awaddr  <= '0;
         wvalid  <= 1'b0;
         wdata   <= '0;
         arvalid <= 1'b0;
         araddr  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         ack0    <= ack0_d;
         ack1    <= ack1_d;
         err     <= err_d;
         rdata   <= rdata_d;
         busy    <= busy_d;
         grant   <= grant_d;
         awvalid <= awvalid_d;
         awaddr  <= awaddr_d;
         wvalid  <= wvalid_d;
         wdata   <= wdata_d;
         arvalid <= arvalid_d;
         araddr  <= araddr_d;
      end
   end

endmodule

// File: tb/tb_axi_reg_arbiter.sv
// Bench for axi_reg_arbiter: behavioural slave, scoreboard of expected completions.
module tb_axi_reg_arbiter;

   localparam int DW = 32;
   localparam int AW = 2;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, err, busy, grant;
   logic [DW-1:0] rdata;
   logic          awvalid, wvalid, arvalid;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata;
   logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
   logic          wresp = 1'b0, rvalid = 1'b0;
   logic [DW-1:0] rData;

   axi_reg_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy), .grant(grant),
      .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wready(wready), .wresp(wresp),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rData(rData), .rvalid(rvalid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Slave configuration, set by the test tasks.
   int            aw_delay = 0, w_delay = 0;
   logic          resp_en = 1'b1, rv_en = 1'b1;
   logic [DW-1:0] rdata_val = '0;

   int   aw_wait = 0, w_wait = 0;
   logic aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
   int   aw_hs = 0, w_hs = 0, ar_hs = 0, aw_hi = 0, w_hi = 0, viol = 0, instab = 0;
   logic [AW-1:0] hs_awaddr = '0, hs_araddr = '0, prev_awaddr = '0;
   logic [DW-1:0] hs_wdata = '0, prev_wdata = '0;
   logic          prev_awvalid = 1'b0, prev_wvalid = 1'b0;

   assign rData = rdata_val;

   // Slave drives its inputs on the falling edge, away from the DUT sampling edge.
   always @(negedge clk) begin
      if (awvalid) begin
         awready <= (aw_wait >= aw_delay);
         aw_wait <= aw_wait + 1;
      end else begin
         awready <= 1'b0;
         aw_wait <= 0;
      end
      if (wvalid) begin
         wready <= (w_wait >= w_delay);
         w_wait <= w_wait + 1;
      end else begin
         wready <= 1'b0;
         w_wait <= 0;
      end
      arready <= arvalid;
      wresp   <= resp_en && aw_got && w_got;
      rvalid  <= rv_en && ar_got;
   end

   always @(posedge clk) begin
      if (rst) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
         ar_got <= 1'b0;
      end else begin
         if (awvalid && awready) begin
            aw_got    <= 1'b1;
            aw_hs     <= aw_hs + 1;
            hs_awaddr <= awaddr;
         end
         if (wvalid && wready) begin
            w_got    <= 1'b1;
            w_hs     <= w_hs + 1;
            hs_wdata <= wdata;
         end
         if (arvalid && arready) begin
            ar_got    <= 1'b1;
            ar_hs     <= ar_hs + 1;
            hs_araddr <= araddr;
         end
         if (wresp || rvalid || ack0 || ack1) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            ar_got <= 1'b0;
         end
         if (awvalid) aw_hi <= aw_hi + 1;
         if (wvalid) w_hi <= w_hi + 1;
         if (ack0 && ack1) viol <= viol + 1;
         if ((awvalid || wvalid) && arvalid) viol <= viol + 1;
         if ((prev_awvalid && awvalid && awaddr != prev_awaddr) ||
             (prev_wvalid && wvalid && wdata != prev_wdata)) instab <= instab + 1;
         prev_awvalid <= awvalid;
         prev_wvalid  <= wvalid;
         prev_awaddr  <= awaddr;
         prev_wdata   <= wdata;
      end
   end

   typedef struct {
      logic          who;
      logic          err;
      logic          chk_rdata;
      logic [DW-1:0] rdata;
      int            lat;
   } exp_t;

   exp_t sb[$];
   logic model_last = 1'b1;

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst        = 1'b0;
      model_last = 1'b1;
   endtask

   // Single transaction from one requester; expectation pushed before driving.
   task automatic do_txn(input logic who, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic exp_err,
                         input logic chk_rd, input logic [DW-1:0] exp_rd, input int exp_lat);
      exp_t e;
      int   lat;
      logic got;
      e.who = who; e.err = exp_err; e.chk_rdata = chk_rd; e.rdata = exp_rd; e.lat = exp_lat;
      sb.push_back(e);
      @(negedge clk);
      if (who) begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end
      lat = 1;
      got = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         lat++;
         if (ack0 || ack1) begin
            got = 1'b1;
            break;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL txn_timeout: no ack within 60 cycles, required ack%0d", who);
      end else begin
         e = sb.pop_front();
         checks++;
         if ({ack1, ack0} !== (2'b01 << e.who)) begin
            errors++;
            $display("FAIL ack_index: got %b required %b", {ack1, ack0}, 2'b01 << e.who);
         end
         checks++;
         if (err !== e.err) begin
            errors++;
            $display("FAIL err: got %b required %b", err, e.err);
         end
         if (e.chk_rdata) begin
            checks++;
            if (rdata !== e.rdata) begin
               errors++;
               $display("FAIL rdata: got %h required %h", rdata, e.rdata);
            end
         end
         checks++;
         if (lat != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d required %0d", lat, e.lat);
         end
         model_last = e.who;
         @(negedge clk);
         checks++;
         if ({busy, err, ack0, ack1} !== 4'b0) begin
            errors++;
            $display("FAIL after_done: busy/err/ack0/ack1 got %b required 0000",
                     {busy, err, ack0, ack1});
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ack0, ack1, err, rdata, busy, grant, awvalid, awaddr, wvalid, wdata,
           arvalid, araddr} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got nonzero (busy=%b awvalid=%b rdata=%h) required 0",
                  busy, awvalid, rdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_write();
      int aw0, w0;
      aw0 = aw_hs; w0 = w_hs;
      aw_delay = 1; w_delay = 1; resp_en = 1'b1;
      do_txn(1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 1'b0, 1'b0, '0, 5);
      checks++;
      if (aw_hs - aw0 != 1 || w_hs - w0 != 1) begin
         errors++;
         $display("FAIL write_handshakes: aw=%0d w=%0d required 1 1", aw_hs - aw0, w_hs - w0);
      end
      checks++;
      if (hs_awaddr !== 2'd2 || hs_wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write_payload: awaddr=%0d wdata=%h required 2 deadbeef",
                  hs_awaddr, hs_wdata);
      end
      aw_delay = 0; w_delay = 0;
   endtask

   task automatic test_read();
      int ar0;
      ar0 = ar_hs;
      rdata_val = 32'h12345678; rv_en = 1'b1;
      do_txn(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b1, 32'h12345678, 4);
      checks++;
      if (ar_hs - ar0 != 1 || hs_araddr !== 2'd1) begin
         errors++;
         $display("FAIL read_addr: handshakes=%0d araddr=%0d required 1 1", ar_hs - ar0,
                  hs_araddr);
      end
   endtask

   task automatic test_ready_skew();
      int awh0, wh0, i0;
      awh0 = aw_hi; wh0 = w_hi; i0 = instab;
      aw_delay = 3; w_delay = 0;
      do_txn(1'b0, 1'b1, 2'd3, 32'hA5A5_0F0F, 1'b0, 1'b0, '0, 7);
      checks++;
      if (aw_hi - awh0 != 4 || w_hi - wh0 != 1) begin
         errors++;
         $display("FAIL skew_valid_cycles: awvalid=%0d wvalid=%0d required 4 1",
                  aw_hi - awh0, w_hi - wh0);
      end
      checks++;
      if (instab != i0) begin
         errors++;
         $display("FAIL skew_stable: payload changed %0d times required 0", instab - i0);
      end
      aw_delay = 0;
   endtask

   task automatic test_timeout();
      resp_en = 1'b0;
      do_txn(1'b0, 1'b1, 2'd0, 32'h1, 1'b1, 1'b0, '0, TO + 3);
      resp_en = 1'b1;
      rv_en   = 1'b0;
      do_txn(1'b1, 1'b0, 2'd2, '0, 1'b1, 1'b1, '0, TO + 3);
      rv_en   = 1'b1;
   endtask

   task automatic test_back_to_back();
      int   rem0, rem1, done, v0;
      logic rr0, rr1;
      exp_t e;
      do_reset();
      v0 = viol;
      rdata_val = 32'h0BAD_F00D;
      for (int i = 0; i < 4; i++) begin
         e.who = ~model_last; e.err = 1'b0; e.chk_rdata = ~model_last;
         e.rdata = 32'h0BAD_F00D; e.lat = 0;
         sb.push_back(e);
         model_last = e.who;
      end
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 32'hCAFE_0001;
      req1 = 1'b1; we1 = 1'b0; addr1 = 2'd3;
      rem0 = 2; rem1 = 2; done = 0; rr0 = 1'b0; rr1 = 1'b0;
      for (int c = 0; c < 200 && done < 4; c++) begin
         @(negedge clk);
         if (rr0) begin req0 = (rem0 > 0); rr0 = 1'b0; end
         if (rr1) begin req1 = (rem1 > 0); rr1 = 1'b0; end
         if (ack0 || ack1) begin
            done++;
            e = sb.pop_front();
            checks++;
            if ({ack1, ack0} !== (2'b01 << e.who) || grant !== e.who) begin
               errors++;
               $display("FAIL rr_order: ack1/ack0=%b grant=%b required ack%0d", {ack1, ack0},
                        grant, e.who);
            end
            checks++;
            if (err !== 1'b0 || (e.chk_rdata && rdata !== e.rdata)) begin
               errors++;
               $display("FAIL rr_result: err=%b rdata=%h required 0 %h", err, rdata, e.rdata);
            end
            if (ack0) begin rem0--; req0 = 1'b0; rr0 = 1'b1; end
            if (ack1) begin rem1--; req1 = 1'b0; rr1 = 1'b1; end
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (done != 4) begin
         errors++;
         $display("FAIL rr_count: completions %0d required 4", done);
      end
      checks++;
      if (viol != v0) begin
         errors++;
         $display("FAIL rr_exclusive: %0d overlap events required 0", viol - v0);
      end
      sb.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int acks;
      resp_en = 1'b0;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 32'h5555_AAAA;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: got %b required 1", busy);
      end
      rst = 1'b1; req0 = 1'b0;
      @(negedge clk);
      checks++;
      if ({awvalid, wvalid, busy} !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset: awvalid/wvalid/busy got %b required 000",
                  {awvalid, wvalid, busy});
      end
      rst = 1'b0; resp_en = 1'b1;
      acks = 0;
      repeat (TO + 6) begin
         @(negedge clk);
         if (ack0 || ack1) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL mid_no_ack: got %0d acks required 0", acks);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_ready_skew();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_reg_arbiter.md
Name: axi_reg_arbiter

Overview:
- Two-requester front end for the AXI-lite-style register slave (single-bit write response, no bvalid/bready, no rready).
- Arbitrates round-robin between two simple req/ack clients and sequences exactly one full read or write transaction at a time on the slave's address/data handshakes.
- Enforces a response timeout and reports errors back to the requester.
- Sits between the control sources (e.g. a CPU bridge and a test sequencer) and the register slave.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 2, register address width.
- TIMEOUT, 16, max cycles to wait for wresp/rvalid after the address/data handshake completes (>=2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  transaction request, level, held until ack.
- we0, we1  in  1  1=write, 0=read; stable while req high.
- addr0, addr1  in  ADDR_WIDTH  target register address.
- wdata0, wdata1  in  DATA_WIDTH  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1=timeout, no response.
- rdata  out  DATA_WIDTH  read result; valid with ack on reads.
- busy  out  1  high in any state except IDLE.
- grant  out  1  index of the requester being served.
- awvalid  out  1  write address valid.
- awaddr  out  ADDR_WIDTH  write address.
- awready  in  1  slave write-address accept.
- wvalid  out  1  write data valid.
- wdata  out  DATA_WIDTH  write data.
- wready  in  1  slave write-data accept.
- wresp  in  1  slave write response (1=OK).
- arvalid  out  1  read address valid.
- araddr  out  ADDR_WIDTH  read address.
- arready  in  1  slave read-address accept.
- rData  in  DATA_WIDTH  slave read data.
- rvalid  in  1  slave read data valid.

Behaviour:
- All outputs registered.
- Reset (rst=1 at posedge):
  - state=IDLE; every output 0 (awaddr, araddr, wdata, rdata = 0).
  - RR pointer favours req0; timeout counter = 0.
  - Reset mid-transaction aborts it with no ack.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, DONE.
- IDLE:
  - Sample req0/req1.
  - If only one is high, grant it.
  - If both are high, grant the one not granted last (req0 first after reset).
  - Latch that requester's we/addr/wdata.
  - Next state is WRITE (we=1) or READ (we=0).
  - In the same edge, drive awvalid=wvalid=1 (write) or arvalid=1 (read).
- WRITE:
  - Hold awvalid until awready is sampled 1; clear awvalid at that edge.
  - wvalid/wready handled independently the same way.
  - awaddr/wdata stay stable while their valid is high.
  - When both handshakes are done (same cycle or different cycles), go to WRESP and clear the counter.
- WRESP:
  - Increment the counter each cycle.
  - wresp=1 -> DONE with err=0.
  - Counter reaches TIMEOUT -> DONE with err=1.
- READ:
  - Hold arvalid until arready is sampled 1, then clear it.
  - Go to RDATA and clear the counter.
- RDATA:
  - rvalid=1 -> capture rData into rdata, err=0, DONE.
  - Timeout -> rdata=0, err=1, DONE.
- DONE:
  - ack[grant]=1 for exactly one cycle with err/rdata valid.
  - Update the RR pointer to grant.
  - Return to IDLE.
- Requester protocol:
  - A requester must drop req in the cycle after ack.
  - A req still high in the following IDLE is a new transaction.
- No new grant until DONE. A req asserted mid-transaction waits; at most one transaction is outstanding.
- Minimum latency from req to ack:
  - Write: 1 (grant) + 1 (aw/w handshake) + 1 (wresp) + 1 (DONE) = 4 cycles, with a single-cycle-ready slave.
  - Read: same count.
- rdata holds its value until the next read completes or reset. err clears on the cycle after ack.
- grant holds its last value while IDLE.

Test Plan:
- Reset → all outputs 0, busy=0. Write issued during WRESP then rst=1 → no ack, awvalid=wvalid=0 next cycle.
- req0 write addr=2 wdata=0xDEADBEEF, slave readies after 1 cycle, wresp=1 → single awvalid/wvalid handshake, awaddr=2, ack0=1 with err=0, busy falls after DONE.
- req1 read addr=1, slave rData=0x12345678, rvalid=1 → arvalid one handshake, araddr=1, ack1=1, rdata=0x12345678, err=0.
- req0 and req1 high together, back-to-back for 4 transactions → grant sequence 0,1,0,1; never two acks in one cycle; never overlapping valids.
- Write addr=0 (slave never asserts wresp) → ack after exactly TIMEOUT=16 WRESP cycles with err=1. Read with rvalid held 0 → err=1, rdata=0.
- awready returned 3 cycles after wready → awvalid held stable 3 extra cycles, wvalid dropped after its own handshake, WRESP entered only after both handshakes.
